multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Parametrised multi-cycle control unit for the 16-bit processor; successor to the fixed FSM controller.
//  Sequences each instruction through fetch/decode/execute, driving the register file, ALU, PC and unified memory.
//  Adds memory ready handshake with timeout, conditional branch/jump, retired-instruction counter, fault state.
// PARAMETERS
//  RA_W        4   register address width; reg_waddr is RA_W+1 bits, MSB=1 means no write
//  IMM_W       8   immediate width; instruction[IMM_W-1:0]; IMM_W <= 8
//  MEM_TIMEOUT 15  max cycles waiting for mem_ready before fault; 0 disables timeout
//  CNT_W       16  retired-instruction counter width
// PORTS
//  clock       in   1        system clock, rising edge
//  reset       in   1        asynchronous, active-high
//  instruction in   16       memory read data during FETCH
//  mem_ready   in   1        memory completed current request (1-cycle pulse or level)
//  flags       in   4        {N,Z,C,F} from PSR
//  reg_waddr   out  RA_W+1   write-back address; {1'b1,0..} = no write
//  op_code     out  4        instruction[15:12]
//  ex_op       out  4        instruction[7:4]
//  imm         out  IMM_W    instruction[IMM_W-1:0]
//  r_dest      out  RA_W     instruction[11:8]
//  r_src       out  RA_W     instruction[3:0]
//  reg_or_imm  out  1        1 = ALU B from r_src, 0 = from imm
//  pc_en       out  1        PC update strobe, exactly one pulse per retired instruction
//  pc_sel      out  2        00 PC+1, 01 PC+sext(imm), 10 reg[r_src]
//  addr_sel    out  1        memory address: 0 = PC, 1 = reg[r_src]
//  mem_req     out  1        memory request, held until mem_ready
//  mem_we      out  1        write qualifier for mem_req
//  retired     out  CNT_W    retired-instruction count, wraps
//  fault       out  1        sticky; set in FAULT
// BEHAVIOUR
//  Reset: state=FETCH; all outputs 0, except reg_waddr={1'b1,{RA_W{1'b0}}}; retired=0; fault=0.
//  All outputs registered. Strobes (pc_en, reg write, mem_req) default to inactive each cycle unless stated.
//  Decode (instruction captured into IR on mem_ready in FETCH):
//   op 0000: ex 0000 NOP->RETIRE; ex 1100 LOAD; ex 1111 STOR; others R-type.
//   op 1000: ex 0100/0101/0110/0011 shift-reg (R-type); ex 1000/0111 shift-imm (I-type); others illegal.
//   op 1100 Bcond (cond=[11:8], disp=imm); op 0100 with ex 1100 Jcond (cond=[11:8], target reg [3:0]).
//   op 0100 other ex, op 1111 illegal -> FAULT; all remaining ops are I-type.
//  Conditions: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0110 GT N; 0111 LE !N; 1110 UC 1; else never.
//  States and transitions:
//   FETCH: mem_req=1, addr_sel=0, mem_we=0; on mem_ready latch IR -> DECODE; else count wait.
//   DECODE: 1 cycle, select path as above.
//   EXEC_R: reg_or_imm=1, reg_waddr={0,r_dest}, pc_sel=00, pc_en=1 -> FETCH (retire).
//   EXEC_I: reg_or_imm=0, reg_waddr={0,r_dest}, pc_sel=00, pc_en=1 -> FETCH (retire); CMPI no write.
//   LD_WAIT: mem_req=1, addr_sel=1; on mem_ready reg_waddr={0,r_dest}, pc_en=1 -> FETCH.
//   ST_WAIT: mem_req=1, mem_we=1, addr_sel=1; on mem_ready pc_en=1 -> FETCH.
//   BRANCH: pc_en=1; pc_sel=01 (Bcond) or 10 (Jcond) if cond true, else 00 -> FETCH.
//   FAULT: all strobes 0, fault=1; exit only by reset.
//  CMP/CMPU/CMPI never write: reg_waddr MSB stays 1.
//  Latency: R/I/NOP/branch = 3 cycles + fetch wait; LOAD/STOR = 3 cycles + fetch wait + mem wait.
//  Timeout: wait counter cleared on entering FETCH/LD_WAIT/ST_WAIT.
//   If MEM_TIMEOUT>0 and counter reaches MEM_TIMEOUT without mem_ready -> FAULT.
//   mem_ready in the same cycle the counter hits the limit wins: no fault.
//  retired increments on every pc_en, wraps 2^CNT_W-1 -> 0, no saturation.
//  mem_ready outside FETCH/LD_WAIT/ST_WAIT is ignored.
//  Reset mid-instruction aborts immediately: no partial write-back, no pc_en, state=FETCH.
// TESTING
//  Reset then ADD (0x0551), mem_ready on 1st cycle -> pc_en one pulse at cycle 3, reg_waddr=0x05, retired=1.
//  LOAD 0x02C3, data mem_ready after 4 cycles -> mem_req held 4 cycles, addr_sel=1, then reg_waddr=0x02, pc_en.
//  Bcond EQ, disp 0xFC: flags Z=1 -> pc_sel=01; Z=0 -> pc_sel=00; cond 1111 -> never taken.
//  MEM_TIMEOUT=15, mem_ready held low in FETCH -> FAULT after 15 cycles, fault=1; ready at cycle 15 -> no fault.
//  Opcode 0xF000 -> FAULT, no pc_en, no write; async reset in FAULT clears fault and returns to FETCH.
//  CNT_W=4, 17 NOPs -> retired=1 (wrap); reset asserted in LD_WAIT -> no write-back, outputs at reset values.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_if.sv
// Unified memory port of the multi-cycle controller: request, write qualifier and
// address select out; instruction word and ready handshake in.
interface multicycle_ctrl_fsm_if;
  logic [15:0] instruction;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;

  modport master (
    input  instruction,
    input  mem_ready,
    output mem_req,
    output mem_we,
    output addr_sel
  );

  modport slave (
    output instruction,
    output mem_ready,
    input  mem_req,
    input  mem_we,
    input  addr_sel
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control unit for the 16-bit processor: fetch/decode/execute sequencing
// with memory ready handshake and timeout, conditional branches, retire counter and fault.
module multicycle_ctrl_fsm #(
  parameter int RA_W        = 4,
  parameter int IMM_W       = 8,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  multicycle_ctrl_fsm_if.master mem,
  input  logic [3:0]           flags,
  output logic [RA_W:0]        reg_waddr,
  output logic [3:0]           op_code,
  output logic [3:0]           ex_op,
  output logic [IMM_W-1:0]     imm,
  output logic [RA_W-1:0]      r_dest,
  output logic [RA_W-1:0]      r_src,
  output logic                 reg_or_imm,
  output logic                 pc_en,
  output logic [1:0]           pc_sel,
  output logic [CNT_W-1:0]     retired,
  output logic                 fault
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_RETIRE,
    S_LD_WAIT, S_ST_WAIT, S_BRANCH, S_FAULT
  } state_t;

  typedef enum logic [2:0] {
    C_NOP, C_R, C_I, C_LD, C_ST, C_B, C_J, C_ILL
  } class_t;

  localparam logic [RA_W:0]    NO_WRITE   = {1'b1, {RA_W{1'b0}}};
  localparam int               TW         = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0]    WAIT_LIMIT = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam logic [TW-1:0]    WAIT_ONE   = TW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Compare encodings: CMP and CMPU are R-type extensions, CMPI is an I-type opcode.
  localparam logic [3:0] EX_CMP  = 4'b1011;
  localparam logic [3:0] EX_CMPU = 4'b1000;
  localparam logic [3:0] OP_CMPI = 4'b1011;

  function automatic class_t classify(input logic [15:0] ins);
    class_t c;
    c = C_I;
    case (ins[15:12])
      4'b0000: begin
        case (ins[7:4])
          4'b0000: c = C_NOP;
          4'b1100: c = C_LD;
          4'b1111: c = C_ST;
          default: c = C_R;
        endcase
      end
      4'b1000: begin
        case (ins[7:4])
          4'b0100, 4'b0101, 4'b0110, 4'b0011: c = C_R;
          4'b1000, 4'b0111:                   c = C_I;
          default:                            c = C_ILL;
        endcase
      end
      4'b1100: c = C_B;
      4'b0100: c = (ins[7:4] == 4'b1100) ? C_J : C_ILL;
      4'b1111: c = C_ILL;
      default: c = C_I;
    endcase
    return c;
  endfunction

  function automatic logic writes_back(input logic [15:0] ins);
    logic is_cmp;
    is_cmp = ((ins[15:12] == 4'b0000) && ((ins[7:4] == EX_CMP) || (ins[7:4] == EX_CMPU)))
           || (ins[15:12] == OP_CMPI);
    return !is_cmp;
  endfunction

  // flags = {N, Z, C, F}; F never participates in a condition.
  function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] f);
    logic t;
    case (cond)
      4'b0000: t = f[2];
      4'b0001: t = !f[2];
      4'b0010: t = f[1];
      4'b0011: t = !f[1];
      4'b0110: t = f[3];
      4'b0111: t = !f[3];
      4'b1110: t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  state_t         state, state_next;
  logic [15:0]    ir, ir_d;
  logic [TW-1:0]  wait_cnt, wait_cnt_d;
  logic           mem_req_q, mem_we_q, addr_sel_q;
  logic           req_d, we_d, asel_d, pc_en_d, roi_d, fault_d;
  logic [1:0]     pc_sel_d;
  logic [RA_W:0]  waddr_d;
  logic           accept, waiting, expired;
  class_t         cls;
  logic [RA_W-1:0] rd;
  logic           unused_flag_f;

  assign cls           = classify(ir);
  assign rd            = RA_W'(ir[11:8]);
  assign unused_flag_f = flags[0];

  assign op_code = ir[15:12];
  assign ex_op   = ir[7:4];
  assign imm     = ir[IMM_W-1:0];
  assign r_dest  = rd;
  assign r_src   = RA_W'(ir[3:0]);

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_we   = mem_we_q;
  assign mem.addr_sel = addr_sel_q;

  // mem_ready only counts while a request is actually on the bus.
  assign accept  = mem_req_q && mem.mem_ready;
  assign waiting = mem_req_q && !mem.mem_ready;
  assign expired = (MEM_TIMEOUT > 0) && waiting && (wait_cnt == WAIT_LIMIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_FETCH;
      ir         <= '0;
      wait_cnt   <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_sel_q <= 1'b0;
      pc_en      <= 1'b0;
      pc_sel     <= 2'b00;
      reg_or_imm <= 1'b0;
      reg_waddr  <= NO_WRITE;
      retired    <= '0;
      fault      <= 1'b0;
    end else begin
      state      <= state_next;
      ir         <= ir_d;
      wait_cnt   <= wait_cnt_d;
      mem_req_q  <= req_d;
      mem_we_q   <= we_d;
      addr_sel_q <= asel_d;
      pc_en      <= pc_en_d;
      pc_sel     <= pc_sel_d;
      reg_or_imm <= roi_d;
      reg_waddr  <= waddr_d;
      fault      <= fault_d;
      if (pc_en_d) retired <= retired + CNT_ONE;
    end
  end

  // Outputs are decided on the transition so they line up with the state they belong to.
  always_comb begin
    state_next = state;
    ir_d       = ir;
    req_d      = 1'b0;
    we_d       = 1'b0;
    asel_d     = 1'b0;
    pc_en_d    = 1'b0;
    pc_sel_d   = 2'b00;
    roi_d      = 1'b0;
    waddr_d    = NO_WRITE;
    fault_d    = 1'b0;

    case (state)
      S_FETCH: begin
        if (accept) begin
          state_next = S_DECODE;
          ir_d       = mem.instruction;
        end else if (expired) begin
          state_next = S_FAULT;
          fault_d    = 1'b1;
        end else begin
          req_d = 1'b1;
        end
      end
      S_DECODE: begin
        case (cls)
          C_NOP: begin
            state_next = S_RETIRE;
            pc_en_d    = 1'b1;
          end
          C_R: begin
            state_next = S_EXEC_R;
            roi_d      = 1'b1;
            pc_en_d    = 1'b1;
            waddr_d    = writes_back(ir) ? {1'b0, rd} : NO_WRITE;
          end
          C_I: begin
            state_next = S_EXEC_I;
            pc_en_d    = 1'b1;
            waddr_d    = writes_back(ir) ? {1'b0, rd} : NO_WRITE;
          end
          C_LD: begin
            state_next = S_LD_WAIT;
            req_d      = 1'b1;
            asel_d     = 1'b1;
          end
          C_ST: begin
            state_next = S_ST_WAIT;
            req_d      = 1'b1;
            we_d       = 1'b1;
            asel_d     = 1'b1;
          end
          C_B: begin
            state_next = S_BRANCH;
            pc_en_d    = 1'b1;
            pc_sel_d   = cond_true(ir[11:8], flags) ? 2'b01 : 2'b00;
          end
          C_J: begin
            state_next = S_BRANCH;
            pc_en_d    = 1'b1;
            pc_sel_d   = cond_true(ir[11:8], flags) ? 2'b10 : 2'b00;
          end
          default: begin
            state_next = S_FAULT;
            fault_d    = 1'b1;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_RETIRE, S_BRANCH: begin
        state_next = S_FETCH;
        req_d      = 1'b1;
      end
      S_LD_WAIT: begin
        if (accept) begin
          state_next = S_FETCH;
          req_d      = 1'b1;
          pc_en_d    = 1'b1;
          waddr_d    = {1'b0, rd};
        end else if (expired) begin
          state_next = S_FAULT;
          fault_d    = 1'b1;
        end else begin
          req_d  = 1'b1;
          asel_d = 1'b1;
        end
      end
      S_ST_WAIT: begin
        if (accept) begin
          state_next = S_FETCH;
          req_d      = 1'b1;
          pc_en_d    = 1'b1;
        end else if (expired) begin
          state_next = S_FAULT;
          fault_d    = 1'b1;
        end else begin
          req_d  = 1'b1;
          we_d   = 1'b1;
          asel_d = 1'b1;
        end
      end
      S_FAULT: begin
        fault_d = 1'b1;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // Wait counter restarts whenever a new request phase begins.
  always_comb begin
    wait_cnt_d = wait_cnt;
    if ((state_next != state) || accept)
      wait_cnt_d = '0;
    else if (waiting)
      wait_cnt_d = wait_cnt + WAIT_ONE;
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: a memory responder issues instructions and
// queues the expected retire record; a monitor checks every pc_en pulse against it.
module tb_multicycle_ctrl_fsm;
  localparam int RA_W = 4, IMM_W = 8, MEM_TIMEOUT = 15, CNT_W = 4;
  localparam logic [RA_W:0] NO_WR = {1'b1, {RA_W{1'b0}}};
  localparam int K_NOP = 0, K_R = 1, K_I = 2, K_LD = 3, K_ST = 4, K_B = 5, K_J = 6, K_ILL = 7;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [3:0]       flags = 4'h0;
  logic [RA_W:0]    reg_waddr;
  logic [3:0]       op_code, ex_op;
  logic [IMM_W-1:0] imm;
  logic [RA_W-1:0]  r_dest, r_src;
  logic             reg_or_imm, pc_en, fault;
  logic [1:0]       pc_sel;
  logic [CNT_W-1:0] retired;

  multicycle_ctrl_fsm_if mem();

  multicycle_ctrl_fsm #(.RA_W(RA_W), .IMM_W(IMM_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .mem(mem), .flags(flags),
    .reg_waddr(reg_waddr), .op_code(op_code), .ex_op(ex_op), .imm(imm),
    .r_dest(r_dest), .r_src(r_src), .reg_or_imm(reg_or_imm), .pc_en(pc_en),
    .pc_sel(pc_sel), .retired(retired), .fault(fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0]      ins;
    logic [RA_W:0]    waddr;
    logic [1:0]       psel;
    logic             roi;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: instruction classes straight from the ISA rules.
  function automatic int kind_of(input logic [15:0] ins);
    logic [3:0] op, ex;
    op = ins[15:12];
    ex = ins[7:4];
    if (op == 4'h0) return (ex == 4'h0) ? K_NOP : (ex == 4'hC) ? K_LD : (ex == 4'hF) ? K_ST : K_R;
    if (op == 4'h8) return (ex inside {4'h4, 4'h5, 4'h6, 4'h3}) ? K_R :
                           (ex inside {4'h8, 4'h7}) ? K_I : K_ILL;
    if (op == 4'hC) return K_B;
    if (op == 4'h4) return (ex == 4'hC) ? K_J : K_ILL;
    if (op == 4'hF) return K_ILL;
    return K_I;
  endfunction

  function automatic bit is_compare(input logic [15:0] ins);
    return (ins[15:12] == 4'h0 && ins[7:4] inside {4'hB, 4'h8}) || ins[15:12] == 4'hB;
  endfunction

  function automatic bit taken(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy;
    n = f[3]; z = f[2]; cy = f[1];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd6:  return n;
      4'd7:  return !n;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] gen_instr();
    logic [15:0] r;
    do begin
      r = 16'($urandom);
      case ($urandom_range(0, 7))
        0: begin r[15:12] = 4'h0; r[7:4] = 4'h0; end
        1: begin r[15:12] = 4'h0; r[7:4] = 4'hC; end
        2: begin r[15:12] = 4'h0; r[7:4] = 4'hF; end
        3: r[15:12] = 4'hC;
        4: begin r[15:12] = 4'h4; r[7:4] = 4'hC; end
        5: r[15:12] = 4'h0;
        6: r[15:12] = 4'h8;
        default: ;
      endcase
    end while (kind_of(r) == K_ILL);
    return r;
  endfunction

  // Monitor: every pc_en must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset) begin
      if (pc_en) begin
        if (sb.size() == 0) begin
          check("unexpected_pc_en", pc_en, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          check("retire_waddr", reg_waddr, mon_e.waddr);
          check("retire_pc_sel", pc_sel, mon_e.psel);
          check("retire_reg_or_imm", reg_or_imm, mon_e.roi);
          check("retire_count", retired, mon_e.cnt);
          check("retire_ir_fields", {op_code, r_dest, ex_op, r_src}, mon_e.ins);
          check("retire_imm", imm, mon_e.ins[7:0]);
        end
      end else begin
        check("idle_no_write", reg_waddr[RA_W], 1'b1);
      end
    end
  end

  task automatic check_reset_values();
    check("reset_waddr", reg_waddr, NO_WR);
    check("reset_ctrl", {pc_en, pc_sel, mem.mem_req, mem.mem_we, mem.addr_sel, reg_or_imm, fault}, 0);
    check("reset_retired", retired, 0);
    check("reset_ir", {op_code, imm}, 0);
  endtask

  task automatic apply_reset();
    mem.mem_ready = 1'b0;
    #2 reset = 1'b1;
    sb.delete();
    model_cnt = 0;
    #1 check_reset_values();
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!mem.mem_req && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("mem_req_seen", mem.mem_req, 1'b1);
  endtask

  // Memory responder: ready on the delay-th cycle of the request.
  task automatic serve(input int delay, input logic [15:0] data, input logic [3:0] fl,
                       input logic is_data, input logic we_exp);
    wait_req();
    check("req_addr_sel", mem.addr_sel, is_data);
    check("req_mem_we", mem.mem_we, we_exp);
    for (int i = 1; i < delay; i++) begin
      @(negedge clock);
      check("mem_req_held", mem.mem_req, 1'b1);
    end
    mem.instruction = data;
    mem.mem_ready   = 1'b1;
    if (!is_data) flags = fl;
    @(negedge clock);
    mem.mem_ready = 1'b0;
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic [3:0] fl, input int d1, input int d2);
    int   k;
    exp_t e;
    k = kind_of(ins);
    if (k != K_ILL) begin
      model_cnt = (model_cnt + 1) % (2 ** CNT_W);
      e.ins   = ins;
      e.waddr = ((k == K_R || k == K_I || k == K_LD) && !is_compare(ins)) ? {1'b0, ins[11:8]} : NO_WR;
      e.psel  = (k == K_B && taken(ins[11:8], fl)) ? 2'b01 :
                (k == K_J && taken(ins[11:8], fl)) ? 2'b10 : 2'b00;
      e.roi   = (k == K_R);
      e.cnt   = CNT_W'(model_cnt);
      sb.push_back(e);
    end
    serve(d1, ins, fl, 1'b0, 1'b0);
    if (k == K_LD || k == K_ST) serve(d2, 16'($urandom), fl, 1'b1, k == K_ST);
  endtask

  initial begin
    mem.instruction = 16'h0;
    mem.mem_ready   = 1'b0;
    apply_reset();

    // ADD straight after reset: decode cycle, then the single retire pulse.
    run_instr(16'h0551, 4'h0, 1, 1);
    check("add_decode_no_pc_en", pc_en, 1'b0);
    @(negedge clock);
    check("add_pc_en", pc_en, 1'b1);
    check("add_waddr", reg_waddr, 5'h05);
    check("add_retired", retired, 1);

    run_instr(16'h02C3, 4'h0, 1, 4);
    run_instr(16'h07F1, 4'h0, 2, 3);
    run_instr(16'h00B1, 4'h0, 1, 1);
    run_instr(16'hB3FF, 4'h0, 1, 1);
    run_instr(16'hC0FC, 4'b0100, 1, 1);
    run_instr(16'hC0FC, 4'b0000, 1, 1);
    run_instr(16'hCFFC, 4'hF, 1, 1);
    run_instr(16'h4EC2, 4'h0, 1, 1);
    run_instr(16'h84A3, 4'h0, 1, 1);
    repeat (3) @(negedge clock);
    check("directed_drained", sb.size(), 0);

    // Fetch timeout: no ready for 15 request cycles.
    apply_reset();
    wait_req();
    repeat (14) @(negedge clock);
    check("timeout_cycle15_no_fault", {fault, mem.mem_req}, 2'b01);
    @(negedge clock);
    check("timeout_fault", {fault, mem.mem_req}, 2'b10);

    // Ready arriving on the 15th cycle wins over the timeout.
    apply_reset();
    run_instr(16'h0551, 4'h0, 15, 1);
    repeat (2) @(negedge clock);
    check("ready_at_limit_no_fault", fault, 1'b0);

    // Illegal opcode: fault, no retire, mem_ready ignored, reset recovers.
    apply_reset();
    run_instr(16'hF000, 4'h0, 1, 1);
    @(negedge clock);
    check("illegal_fault", fault, 1'b1);
    check("illegal_no_write", reg_waddr, NO_WR);
    mem.mem_ready = 1'b1;
    repeat (5) @(negedge clock);
    mem.mem_ready = 1'b0;
    check("fault_sticky", {fault, pc_en, mem.mem_req}, 3'b100);
    apply_reset();
    wait_req();
    check("fault_cleared", fault, 1'b0);

    // Reset while waiting on load data: nothing retires.
    apply_reset();
    serve(1, 16'h02C3, 4'h0, 1'b0, 1'b0);
    wait_req();
    check("ld_wait_addr_sel", mem.addr_sel, 1'b1);
    @(negedge clock);
    apply_reset();
    repeat (3) @(negedge clock);
    check("ld_abort_retired", retired, 0);

    // Counter wrap with a 4-bit count.
    apply_reset();
    for (int i = 0; i < 17; i++)
      run_instr({4'h0, 4'($urandom), 4'h0, 4'($urandom)}, 4'($urandom), $urandom_range(1, 3), 1);
    repeat (2) @(negedge clock);
    check("nop_wrap_retired", retired, 1);

    apply_reset();
    for (int i = 0; i < 150; i++)
      run_instr(gen_instr(), 4'($urandom), $urandom_range(1, 4), $urandom_range(1, 4));
    repeat (4) @(negedge clock);
    check("random_drained", sb.size(), 0);
    check("random_no_fault", fault, 1'b0);

    apply_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
